// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR), one stage per amount bit, tag carried alongside.
// Latency: S = $clog2(WIDTH) cycles from the accepting edge to out_valid.
// Backpressure: stalled stages hold their contents; empty stages still fill; in_ready drops only when every stage is full.
module shifter_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [31:0]      in_amt,
  input  logic [2:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam int S = $clog2(WIDTH);

  localparam logic [2:0] MODE_SLL = 3'd0;
  localparam logic [2:0] MODE_SRL = 3'd1;
  localparam logic [2:0] MODE_SRA = 3'd2;
  localparam logic [2:0] MODE_ROL = 3'd3;
  localparam logic [2:0] MODE_ROR = 3'd4;

  // Stage registers R[1..S]
  logic [S:1]       r_vld;
  logic [WIDTH-1:0] r_data [1:S];
  logic [S-1:0]     r_amt  [1:S];
  logic [2:0]       r_mode [1:S];
  logic             r_ovf  [1:S];
  logic [TAG_W-1:0] r_tag  [1:S];

  // Stage k inputs (stage 0 straight from the ports) and shifted outputs
  logic [WIDTH-1:0] si_data [0:S-1];
  logic [S-1:0]     si_amt  [0:S-1];
  logic [2:0]       si_mode [0:S-1];
  logic [TAG_W-1:0] si_tag  [0:S-1];
  logic [S-1:0]     si_ovf;
  logic [S-1:0]     si_vld;
  logic [WIDTH-1:0] so_data [0:S-1];

  logic [S:1] adv;

  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                input logic [2:0] m, input int sh);
    logic [WIDTH-1:0] r;
    case (m)
      MODE_SLL: r = d << sh;
      MODE_SRL: r = d >> sh;
      MODE_SRA: r = $signed(d) >>> sh;
      MODE_ROL: r = (d << sh) | (d >> (WIDTH - sh));
      MODE_ROR: r = (d >> sh) | (d << (WIDTH - sh));
      default:  r = d;
    endcase
    return r;
  endfunction

  // SRA keeps the original MSB in the top bit at every stage, so it is the fill value here
  function automatic logic [WIDTH-1:0] apply_ovf(input logic [WIDTH-1:0] d,
                                                 input logic [2:0] m, input logic ovf);
    logic [WIDTH-1:0] r;
    r = d;
    if (ovf) begin
      case (m)
        MODE_SLL, MODE_SRL: r = '0;
        MODE_SRA:           r = {WIDTH{d[WIDTH-1]}};
        default:            r = d;
      endcase
    end
    return r;
  endfunction

  for (genvar k = 0; k < S; k++) begin : g_stage
    if (k == 0) begin : g_in
      assign si_data[0] = in_data;
      assign si_amt[0]  = in_amt[S-1:0];
      assign si_mode[0] = in_mode;
      assign si_tag[0]  = in_tag;
      assign si_ovf[0]  = |in_amt[31:S];
      assign si_vld[0]  = in_valid;
    end else begin : g_reg
      assign si_data[k] = r_data[k];
      assign si_amt[k]  = r_amt[k];
      assign si_mode[k] = r_mode[k];
      assign si_tag[k]  = r_tag[k];
      assign si_ovf[k]  = r_ovf[k];
      assign si_vld[k]  = r_vld[k];
    end

    logic [WIDTH-1:0] shifted;
    assign shifted = si_amt[k][k] ? shift_by(si_data[k], si_mode[k], 1 << k) : si_data[k];

    if (k == S - 1) begin : g_last
      assign so_data[k] = apply_ovf(shifted, si_mode[k], si_ovf[k]);
    end else begin : g_mid
      assign so_data[k] = shifted;
    end
  end

  // adv[k]: R[k] may load, i.e. it is empty or something downstream frees a slot
  always_comb begin
    logic room;
    room = out_ready;
    adv  = '0;
    for (int k = S; k >= 1; k--) begin
      room   = room | ~r_vld[k];
      adv[k] = room;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      for (int k = 1; k <= S; k++) begin
        r_data[k] <= '0;
        r_amt[k]  <= '0;
        r_mode[k] <= '0;
        r_ovf[k]  <= 1'b0;
        r_tag[k]  <= '0;
      end
    end else begin
      for (int k = 1; k <= S; k++) begin
        if (adv[k]) begin
          r_vld[k]  <= si_vld[k-1];
          r_data[k] <= so_data[k-1];
          r_amt[k]  <= si_amt[k-1];
          r_mode[k] <= si_mode[k-1];
          r_ovf[k]  <= si_ovf[k-1];
          r_tag[k]  <= si_tag[k-1];
        end
      end
    end
  end

  assign in_ready  = adv[1];
  assign out_valid = r_vld[S];
  assign out_data  = r_data[S];
  assign out_tag   = r_tag[S];
  assign busy      = |r_vld;

endmodule
